// File: rtl/timer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_pkg: shared state encoding and width defaults for timer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package timer_pkg;

  localparam int TIMER_CNT_W = 64;
  localparam int TIMER_DIV_W = 4;

  // 2'b11 is not a legal state; the FSM decodes it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_prescaler: divide-by-(div_val+1) tick generator             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W = TIMER_DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run,
  input  logic             hold,
  input  logic             restart,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] r_pre_cnt;
  logic [DIV_W-1:0] r_div_val_q;
  logic             r_div_en_q;
  logic [DIV_W-1:0] w_pre_cnt_nxt;
  logic             w_cfg_changed;
  logic             w_at_top;

  // Any reprogramming of the divider restarts the period from zero.
  assign w_cfg_changed = (div_en != r_div_en_q) || (div_val != r_div_val_q);
  assign w_at_top      = (r_pre_cnt == div_val);

  always_comb begin
    w_pre_cnt_nxt = r_pre_cnt;
    if (restart || w_cfg_changed || !(run || hold)) begin
      w_pre_cnt_nxt = '0;
    end else if (run && div_en) begin
      w_pre_cnt_nxt = w_at_top ? '0 : (r_pre_cnt + {{(DIV_W-1){1'b0}}, 1'b1});
    end else if (run) begin
      w_pre_cnt_nxt = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre_cnt   <= '0;
      r_div_val_q <= '0;
      r_div_en_q  <= 1'b0;
    end else begin
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_div_val_q <= div_val;
      r_div_en_q  <= div_en;
    end
  end

  assign tick = run && (!div_en || w_at_top);

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | timer_ctrl: run/halt sequencing, counter clear and compare IRQ    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = TIMER_CNT_W,
  parameter int DIV_W = TIMER_DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             clr_req,
  input  logic             dbg_mode,
  input  logic             halt_req,
  input  logic             int_en,
  input  logic             int_clr,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_timer_en,
  output logic             cnt_en,
  output logic             count_clr,
  output logic             halt_ack,
  output logic             int_st,
  output logic             tim_int
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;
  logic   w_halted;
  logic   w_halt_req;
  logic   w_match;
  logic   r_timer_en_q;
  logic   r_count_clr;
  logic   r_int_st;

  assign w_halt_req = dbg_mode && halt_req;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping timer_en out of HALT takes priority over resuming.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      IDLE: begin
        if (timer_en) w_state_nxt = RUN;
      end
      RUN: begin
        w_run = 1'b1;
        if (!timer_en)      w_state_nxt = IDLE;
        else if (w_halt_req) w_state_nxt = HALT;
      end
      HALT: begin
        w_halted = 1'b1;
        if (!timer_en)        w_state_nxt = IDLE;
        else if (!w_halt_req) w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run       (w_run),
    .hold      (w_halted),
    .restart   (clr_req),
    .div_en    (div_en),
    .div_val   (div_val),
    .tick      (cnt_en)
  );

  assign w_match = (count == cmp_val);

  // A match in the same cycle as int_clr keeps the status set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_timer_en_q <= 1'b0;
      r_count_clr  <= 1'b0;
      r_int_st     <= 1'b0;
    end else begin
      r_timer_en_q <= timer_en;
      r_count_clr  <= clr_req || (r_timer_en_q && !timer_en);
      if (w_match)      r_int_st <= 1'b1;
      else if (int_clr) r_int_st <= 1'b0;
    end
  end

  assign cnt_timer_en = w_run;
  assign halt_ack     = w_halted;
  assign count_clr    = r_count_clr;
  assign int_st       = r_int_st;
  assign tim_int      = r_int_st && int_en;

endmodule
`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Control and sequencing block for the 64-bit timer counter. It turns software enables into the counter's `cnt_timer_en`, `cnt_en` and `count_clr` controls, and applies a programmable prescaler and debug halt. It compares the live count against a 64-bit compare value and raises a sticky, maskable interrupt. It sits between the register interface and the 64-bit counter, in the same `sys_clk` domain.

## Interface
- `CNT_W`, 64, counter and compare width
- `DIV_W`, 4, prescaler divide-value width
- `sys_clk`  in  1  single clock; all logic rises on posedge
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `timer_en`  in  1  software timer enable (level)
- `div_en`  in  1  prescaler enable
- `div_val`  in  DIV_W  prescaler value; tick period is div_val+1 cycles
- `clr_req`  in  1  software counter-clear request (1-cycle pulse)
- `dbg_mode`  in  1  debug mode active
- `halt_req`  in  1  debug halt request (level)
- `int_en`  in  1  interrupt mask
- `int_clr`  in  1  interrupt status clear (1-cycle pulse)
- `cmp_val`  in  CNT_W  compare value
- `count`  in  CNT_W  live counter value
- `cnt_timer_en`  out  1  counter run enable
- `cnt_en`  out  1  counter increment tick
- `count_clr`  out  1  counter synchronous clear (1-cycle pulse)
- `halt_ack`  out  1  high while halted
- `int_st`  out  1  sticky compare-match status
- `tim_int`  out  1  interrupt = int_st & int_en

## Operation
- **States:**
  - IDLE: timer off.
  - RUN: timer counting.
  - HALT: debug freeze.
- **Transitions:**
  - IDLE→RUN when `timer_en`=1.
  - RUN→IDLE when `timer_en`=0.
  - RUN→HALT when `dbg_mode`&`halt_req`.
  - HALT→RUN when !(`dbg_mode`&`halt_req`) and `timer_en`=1.
  - HALT→IDLE when `timer_en`=0; this check has priority over resume.
- **Prescaler:** counter `pre_cnt` (DIV_W bits).
  - Advances only in RUN with `div_en`=1.
  - Wraps to 0 after reaching `div_val`.
  - Held in HALT.
  - Forced to 0 in IDLE, on `clr_req`, and on any change of `div_en` or `div_val` (change detected against registered copies).
- **Outputs derived from state:**
  - `cnt_timer_en` = (state==RUN).
  - `cnt_en` = (state==RUN) & (!`div_en` | `pre_cnt`==`div_val`).
  - `div_val`=0 with `div_en`=1 ticks every cycle.
  - `halt_ack` = (state==HALT).
- **`count_clr`:** registered pulse, asserted the cycle after either `clr_req`=1 or a `timer_en` 1→0 transition is sampled. Two qualifying events in consecutive cycles produce two consecutive pulses.
- **Compare:**
  - Match = (`count`==`cmp_val`), evaluated every cycle in every state.
  - `int_st` sets on match and clears on `int_clr`.
  - Simultaneous match and `int_clr`: set wins.
  - `int_clr` while the count still equals `cmp_val` therefore has no effect.
- **`tim_int`:** combinational AND of `int_st` and `int_en`. Masking does not clear `int_st`.

## Timing
- **Reset values:**
  - state = IDLE, `pre_cnt` = 0.
  - All outputs 0.
  - Registered `div_en`, `div_val` and `timer_en` copies = 0.
- **Reset mid-operation:** immediate return to the reset values, independent of clock.
- **Start:** `timer_en` sampled high at edge k gives RUN and `cnt_timer_en`=1 after k.
  - `div_en`=0: `cnt_en`=1 from that cycle, so the count increments at edges k+1, k+2, ….
  - `div_en`=1: first `cnt_en` in the (`div_val`+1)th RUN cycle.
- **Stop:** `timer_en` sampled low at edge k gives IDLE and `cnt_en`=0 after k. `count_clr`=1 for the single cycle after edge k.
- **Halt:** `halt_req` sampled at edge k gives `halt_ack`=1 and `cnt_en`=0 after k. Resume continues from the held `pre_cnt`.
- **Compare latency:** one cycle, i.e. match during cycle n gives `int_st`=1 after edge n.
- **Timer off:** `clr_req` in IDLE still pulses `count_clr`.

## Structure
- Shared package `timer_pkg`:
  - state encoding: IDLE=2'b00, RUN=2'b01, HALT=2'b10 (2'b11 decodes to IDLE);
  - `CNT_W` and `DIV_W` defaults.
- Sub-module `timer_prescaler`:
  - holds `pre_cnt`, the change-detect registers and the tick decode;
  - inputs are run, hold and restart;
  - output is the tick.
- FSM, `count_clr` generation and compare/interrupt logic live in `timer_ctrl`.

## Test plan
- **Free-run start:** reset, then `timer_en`=1, `div_en`=0 → `cnt_en` high every cycle from the cycle after the sampling edge; `count_clr`=0.
- **Prescaler:** `div_en`=1, `div_val`=3 → `cnt_en` high 1 cycle in 4. Changing `div_val` to 1 mid-period restarts the prescaler; the next tick arrives 2 cycles later.
- **Stop and clear:** `timer_en` 1→0 → `cnt_en`=0 and one `count_clr` pulse. `clr_req` in IDLE → one `count_clr` pulse.
- **Debug halt:** `dbg_mode`=1, `halt_req`=1 during a `div_val`=3 run with `pre_cnt`=2 → `halt_ack`=1 and no ticks. On release, the next tick comes after exactly 2 cycles.
- **Compare:**
  - `cmp_val`=5, count reaches 5 → `int_st`=1 next cycle.
  - `int_en`=0 → `tim_int`=0; `int_en`=1 → `tim_int`=1.
  - `int_clr` while count==5 → `int_st` stays 1; `int_clr` at count=6 → `int_st`=0.
- **Async reset mid-RUN:** assert `sys_rst_n`=0 → all outputs 0 and state IDLE without a clock edge.
